// File: rtl/symbol_sequencer.sv
// symbol_sequencer: plays a rewritable table of 2-bit symbols, each held HOLD cycles, with start/done handshake.
// Optional SEQ_LOOP_EN adds a loop input that wraps playback back to entry 0 without a gap.
module symbol_sequencer #(
    parameter int NSYM = 9,
    parameter int AW   = 4,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          reset,
`ifdef SEQ_LOOP_EN
    input  logic          loop,
`endif
    input  logic          start,
    input  logic [AW-1:0] len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    output logic [1:0]    a,
    output logic          a_valid,
    output logic          busy,
    output logic          done
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam int NDEF = NSYM < 9 ? NSYM : 9;
    localparam logic [AW:0] NSYM_W = (AW+1)'(NSYM);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [17:0] DEF = {2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t        state, state_n;
    logic [1:0]    tbl [NSYM];
    logic [AW-1:0] idx, idx_n, nxt;
    logic [AW:0]   len_q, len_n, len_c;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [1:0]    a_n;
    logic          a_valid_n, busy_n, done_n, wr_ok, loop_on, last_sym;

`ifdef SEQ_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    assign wr_ok    = wr_en && state != PLAY && {1'b0, wr_addr} < NSYM_W;
    assign len_c    = {1'b0, len} > NSYM_W ? NSYM_W : {1'b0, len};
    assign last_sym = {1'b0, idx} == len_q - (AW+1)'(1);
    assign nxt      = last_sym ? '0 : idx + AW'(1);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        hold_n    = hold_cnt;
        len_n     = len_q;
        a_n       = a;
        a_valid_n = a_valid;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            IDLE: if (start) begin
                len_n  = len_c;
                idx_n  = '0;
                hold_n = '0;
                if (len_c == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    // a same-edge write to entry 0 must be seen by the first symbol
                    state_n   = PLAY;
                    a_n       = (wr_ok && wr_addr == '0) ? wr_data : tbl[0];
                    a_valid_n = 1'b1;
                    busy_n    = 1'b1;
                end
            end
            PLAY: if (hold_cnt != HOLD_LAST) begin
                hold_n = hold_cnt + HW'(1);
            end else begin
                hold_n = '0;
                if (last_sym && !loop_on) begin
                    state_n   = DONE;
                    a_n       = 2'd0;
                    a_valid_n = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                end else begin
                    idx_n = nxt;
                    a_n   = tbl[nxt];
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            len_q    <= '0;
            a        <= 2'd0;
            a_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            hold_cnt <= hold_n;
            len_q    <= len_n;
            a        <= a_n;
            a_valid  <= a_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSYM; i++) tbl[i] <= 2'd0;
            for (int i = 0; i < NDEF; i++) tbl[i] <= DEF[2*i +: 2];
        end else if (wr_ok) begin
            tbl[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_symbol_sequencer.sv
// tb_symbol_sequencer: scoreboard bench for symbol_sequencer; loop scenario runs only with SEQ_LOOP_EN.
module tb_symbol_sequencer;
    localparam int NSYM = 9;
    localparam int AW   = 4;
    localparam int HOLD = 2;
    localparam logic [17:0] DEF_SEQ = {2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    localparam logic [17:0] MOD_SEQ = {2'd3, 2'd3, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2};

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] len = '0, wr_addr = '0;
    logic [1:0]    wr_data = 2'd0;
    logic [1:0]    a;
    logic          a_valid, busy, done;
`ifdef SEQ_LOOP_EN
    logic          loop = 1'b0;
`endif
    int            passed = 0, total = 0;
    logic [4:0]    sb [$];

    always #5 clk = ~clk;

    symbol_sequencer #(.NSYM(NSYM), .AW(AW), .HOLD(HOLD)) dut (
        .clk(clk), .reset(reset),
`ifdef SEQ_LOOP_EN
        .loop(loop),
`endif
        .start(start), .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .a(a), .a_valid(a_valid), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // fields are {a, a_valid, busy, done}
    always @(negedge clk) begin
        if (a_valid | busy | done) begin
            if (sb.size() == 0) check("unexpected output", {27'd0, a, a_valid, busy, done}, 32'd0);
            else check("playback", {27'd0, a, a_valid, busy, done}, {27'd0, sb.pop_front()});
        end
    end

    task automatic push_run(input logic [17:0] syms, input int n);
        for (int i = 0; i < n; i++)
            for (int h = 0; h < HOLD; h++) sb.push_back({syms[2*i +: 2], 3'b110});
        sb.push_back(5'b00001);
    endtask

    task automatic start_run(input int l);
        @(posedge clk); #1 start = 1'b1; len = AW'(l);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic write(input int addr, input logic [1:0] d);
        @(posedge clk); #1 wr_en = 1'b1; wr_addr = AW'(addr); wr_data = d;
        @(posedge clk); #1 wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check(name, sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1 check("reset state", {28'd0, a, a_valid, busy, done}, 32'd0);
        #11 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle after reset", {28'd0, a, a_valid, busy, done}, 32'd0);

        push_run(DEF_SEQ, 9);
        start_run(9);
        drain("default run len=9");

        write(0, 2'd3);
        push_run(2'd3, 1);
        start_run(1);
        drain("len=1 after write");

        push_run(2'd2, 1);
        @(posedge clk); #1 start = 1'b1; len = AW'(1); wr_en = 1'b1; wr_addr = '0; wr_data = 2'd2;
        @(posedge clk); #1 start = 1'b0; wr_en = 1'b0;
        drain("same-edge write+start");

        push_run(18'd0, 0);
        start_run(0);
        drain("len=0");

        push_run(MOD_SEQ, 9);
        start_run(9);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async reset abort", {28'd0, a, a_valid, busy, done}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        push_run(DEF_SEQ, 9);
        start_run(9);
        drain("table restored by reset");

        push_run(DEF_SEQ, 9);
        start_run(12);
        repeat (3) @(posedge clk);
        #1 wr_en = 1'b1; wr_addr = AW'(3); wr_data = 2'd0; start = 1'b1; len = AW'(1);
        @(posedge clk); #1 wr_en = 1'b0; start = 1'b0;
        drain("len=12 clamp, play interference");
        push_run(DEF_SEQ, 4);
        start_run(4);
        drain("write during play dropped");

`ifdef SEQ_LOOP_EN
        for (int i = 0; i < 12; i++) sb.push_back(5'b01110);
        sb.push_back(5'b00001);
        @(posedge clk); #1 start = 1'b1; len = AW'(2); loop = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 loop = 1'b0;
        drain("loop then release");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
